// File: rtl/core_fpu_scoreboard.sv
// FP issue scoreboard: register/unit hazard stalls and single-port write-back arbiter.
// Optional macro CORE_FPU_SB_WB_BYPASS_EN lets hazards see this cycle's write-back clear.
`timescale 1ns/1ps
module core_fpu_scoreboard #(
   parameter int LAT_ADD  = 4,
   parameter int LAT_MUL  = 3,
   parameter int LAT_DIV  = 10,
   parameter int LAT_SQRT = 12,
   parameter int LAT_CVT  = 2
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        ISSUE_VALID,
   input  logic [2:0]  ISSUE_UNIT,
   input  logic [4:0]  ISSUE_FRD,
   input  logic        ISSUE_FRD_WE,
   input  logic [4:0]  ISSUE_FRS1,
   input  logic [4:0]  ISSUE_FRS2,
   input  logic [1:0]  ISSUE_FRS_USE,
   input  logic        FLUSH,
   output logic        STALL,
   output logic [4:0]  UNIT_BUSY,
   output logic [31:0] FREG_BUSY,
   output logic        WB_VALID,
   output logic [4:0]  WB_FRD,
   output logic        WB_FWE,
   output logic [2:0]  WB_UNIT
);

   logic [4:0]  cnt [5];
   logic [4:0]  frd_q [5];
   logic [4:0]  fwe_q;

   logic [4:0]  done;
   logic [4:0]  win_oh;
   logic        win_any;
   logic [2:0]  win_unit;
   logic [4:0]  win_frd;
   logic        win_fwe;
   logic [31:0] clr_mask;
   logic [31:0] set_mask;
   logic [31:0] hz_busy;
   logic [7:0]  ub_pad;
   logic        unit_ok;
   logic        accept;
   logic [4:0]  iss_oh;
   logic [4:0]  ub_nxt;
   logic [31:0] fb_nxt;

   function automatic logic [4:0] lat_m1(input int u);
      int l;
      case (u)
         0:       l = LAT_ADD;
         1:       l = LAT_MUL;
         2:       l = LAT_DIV;
         3:       l = LAT_SQRT;
         default: l = LAT_CVT;
      endcase
      return 5'(l - 1);
   endfunction

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         done[i] = UNIT_BUSY[i] && (cnt[i] == 5'd0);
      end
   end

   // Fixed priority: CVT > ADD > MUL > SQRT > DIV
   always_comb begin
      win_oh = 5'b0;
      if (done[4])      win_oh = 5'b10000;
      else if (done[0]) win_oh = 5'b00001;
      else if (done[1]) win_oh = 5'b00010;
      else if (done[3]) win_oh = 5'b01000;
      else if (done[2]) win_oh = 5'b00100;
   end

   always_comb begin
      win_any  = 1'b1;
      win_unit = 3'd0;
      win_frd  = 5'd0;
      win_fwe  = 1'b0;
      unique case (1'b1)
         win_oh[0]: begin
            win_unit = 3'd0;
            win_frd  = frd_q[0];
            win_fwe  = fwe_q[0];
         end
         win_oh[1]: begin
            win_unit = 3'd1;
            win_frd  = frd_q[1];
            win_fwe  = fwe_q[1];
         end
         win_oh[2]: begin
            win_unit = 3'd2;
            win_frd  = frd_q[2];
            win_fwe  = fwe_q[2];
         end
         win_oh[3]: begin
            win_unit = 3'd3;
            win_frd  = frd_q[3];
            win_fwe  = fwe_q[3];
         end
         win_oh[4]: begin
            win_unit = 3'd4;
            win_frd  = frd_q[4];
            win_fwe  = fwe_q[4];
         end
         default: win_any = 1'b0;
      endcase
   end

   always_comb begin
      clr_mask = '0;
      if (win_any && win_fwe) begin
         clr_mask = 32'd1 << win_frd;
      end
`ifdef CORE_FPU_SB_WB_BYPASS_EN
      hz_busy = FREG_BUSY & ~clr_mask;
`else
      hz_busy = FREG_BUSY;
`endif
   end

   always_comb begin
      ub_pad  = {3'b000, UNIT_BUSY};
      unit_ok = (ISSUE_UNIT < 3'd5);
      STALL   = ISSUE_VALID && unit_ok &&
                (ub_pad[ISSUE_UNIT] ||
                 (ISSUE_FRS_USE[0] && hz_busy[ISSUE_FRS1]) ||
                 (ISSUE_FRS_USE[1] && hz_busy[ISSUE_FRS2]) ||
                 (ISSUE_FRD_WE && hz_busy[ISSUE_FRD]));
      accept  = ISSUE_VALID && !STALL && unit_ok && !FLUSH;
   end

   always_comb begin
      iss_oh   = '0;
      set_mask = '0;
      if (accept) begin
         iss_oh = 5'd1 << ISSUE_UNIT;
         if (ISSUE_FRD_WE) begin
            set_mask = 32'd1 << ISSUE_FRD;
         end
      end
      // Clear first so a same-register set on this edge wins
      ub_nxt = (UNIT_BUSY & ~win_oh) | iss_oh;
      fb_nxt = (FREG_BUSY & ~clr_mask) | set_mask;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         UNIT_BUSY <= '0;
         FREG_BUSY <= '0;
         WB_VALID  <= 1'b0;
         WB_FRD    <= '0;
         WB_FWE    <= 1'b0;
         WB_UNIT   <= '0;
         fwe_q     <= '0;
         for (int i = 0; i < 5; i++) begin
            cnt[i]   <= '0;
            frd_q[i] <= '0;
         end
      end else if (FLUSH) begin
         UNIT_BUSY <= '0;
         FREG_BUSY <= '0;
         WB_VALID  <= 1'b0;
         for (int i = 0; i < 5; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         UNIT_BUSY <= ub_nxt;
         FREG_BUSY <= fb_nxt;
         WB_VALID  <= win_any;
         if (win_any) begin
            WB_FRD  <= win_frd;
            WB_FWE  <= win_fwe;
            WB_UNIT <= win_unit;
         end
         for (int i = 0; i < 5; i++) begin
            if (iss_oh[i]) begin
               cnt[i]   <= lat_m1(i);
               frd_q[i] <= ISSUE_FRD;
               fwe_q[i] <= ISSUE_FRD_WE;
            end else if (cnt[i] != 5'd0) begin
               cnt[i] <= cnt[i] - 5'd1;
            end
         end
      end
   end

endmodule
